alu_shifter_right_seq: RTL and testbench

//  Iterative right shifter: the inverse-direction companion of the ALU's combinational left shifter.

---
 rtl/alu_shifter_right_seq.sv | 79 +++++++
 tb/tb_alu_shifter_right_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_shifter_right_seq.sv
// Iterative right shifter (logical/arithmetic, sticky), one bit per clock; result valid min(amt,WIDTH)+1 edges after accept.
// One op in flight: in_ready only in IDLE, result held in DONE until out_ready.
module alu_shifter_right_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic             in_arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sticky,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [SHW:0] CNT_MAX = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

  state_t           state, state_nxt;
  logic [SHW:0]     amt_ext, amt_clamp, cnt;
  logic [WIDTH-1:0] data_reg;
  logic             arith_reg, sticky, accept, fill;

  // Amounts beyond WIDTH behave exactly like WIDTH, so the counter never needs more.
  assign amt_ext   = {1'b0, in_amt};
  assign amt_clamp = (amt_ext > CNT_MAX) ? CNT_MAX : amt_ext;
  assign accept    = in_valid && (state == IDLE);
  assign fill      = arith_reg & data_reg[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = (amt_clamp == '0) ? DONE : SHIFT;
      SHIFT:   if (cnt == CNT_ONE) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg  <= '0;
      arith_reg <= 1'b0;
      sticky    <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      data_reg  <= in_data;
      arith_reg <= in_arith;
      sticky    <= 1'b0;
      cnt       <= amt_clamp;
    end else if (state == SHIFT) begin
      data_reg  <= {fill, data_reg[WIDTH-1:1]};
      sticky    <= sticky | data_reg[0];
      cnt       <= cnt - CNT_ONE;
    end
  end

  assign out_data   = data_reg;
  assign out_sticky = sticky;

endmodule

// File: tb/tb_alu_shifter_right_seq.sv
// Bench for alu_shifter_right_seq: vector table, directed corner sequences, random ops with a reference model.
module tb_alu_shifter_right_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_arith;
  logic [7:0] in_data;
  logic [3:0] in_amt;
  logic       out_valid, out_ready, out_sticky, busy;
  logic [7:0] out_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] d;
    logic [3:0] amt;
    logic       arith;
    logic [7:0] ed;
    logic       es;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       s;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];

  alu_shifter_right_seq #(.WIDTH(8), .SHW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_arith(in_arith),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sticky(out_sticky), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: shift a sign/zero-extended 16-bit copy, sticky from a mask of the dropped bits.
  function automatic void model(input logic [7:0] d, input logic [3:0] a, input logic ar,
                                output logic [7:0] r, output logic s);
    int          n;
    logic [15:0] ext;
    logic [8:0]  m;
    n   = (a > 4'd8) ? 8 : int'(a);
    ext = {(ar ? {8{d[7]}} : 8'h00), d};
    ext = ext >> n;
    r   = ext[7:0];
    m   = (9'h1 << n) - 9'h1;
    s   = |({1'b0, d} & m);
  endfunction

  task automatic run_op(input logic [7:0] d, input logic [3:0] a, input logic ar,
                        input logic [7:0] ed, input logic es, input int stall, input string tag);
    int   lat;
    int   elat;
    exp_t e;
    exp_t got;
    elat = ((a > 4'd8) ? 8 : int'(a)) + 1;
    @(negedge clk);
    chk({tag, " in_ready idle"}, in_ready, 1);
    in_data = d; in_amt = a; in_arith = ar; in_valid = 1'b1;
    out_ready = (stall == 0);
    e.d = ed; e.s = es;
    sb.push_back(e);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0; in_data = ~d; in_amt = 4'd0; in_arith = ~ar;
    chk({tag, " busy"}, busy, 1);
    chk({tag, " in_ready busy"}, in_ready, 0);
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, " latency"}, lat, elat);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      chk({tag, " stall valid"}, out_valid, 1);
      chk({tag, " stall data"}, out_data, ed);
      chk({tag, " stall in_ready"}, in_ready, 0);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 1, 0);
    end else begin
      got = sb.pop_front();
      chk({tag, " data"}, out_data, got.d);
      chk({tag, " sticky"}, out_sticky, got.s);
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, " valid drop"}, out_valid, 0);
    chk({tag, " back idle"}, in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd, r;
    logic [3:0] ra;
    logic       rar, s;

    vecs[0] = '{8'hB4, 4'd3,  1'b0, 8'h16, 1'b1};
    vecs[1] = '{8'h90, 4'd2,  1'b1, 8'hE4, 1'b0};
    vecs[2] = '{8'h5A, 4'd0,  1'b0, 8'h5A, 1'b0};
    vecs[3] = '{8'h81, 4'd15, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'h81, 4'd15, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{8'hFF, 4'd8,  1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h80, 4'd7,  1'b1, 8'hFF, 1'b0};
    vecs[7] = '{8'h01, 4'd1,  1'b0, 8'h00, 1'b1};
    vecs[8] = '{8'h7F, 4'd4,  1'b1, 8'h07, 1'b1};
    vecs[9] = '{8'hC3, 4'd9,  1'b1, 8'hFF, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_amt = 4'd0;
    in_arith = 1'b0; out_ready = 1'b0;
    #12;
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset out_data", out_data, 0);
    chk("reset sticky", out_sticky, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset in_ready", in_ready, 1);

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].d, vecs[i].amt, vecs[i].arith, vecs[i].ed, vecs[i].es, i % 2, $sformatf("vec%0d", i));

    // Backpressure: result held 5 cycles with new requests knocking.
    run_op(8'hB4, 4'd3, 1'b0, 8'h16, 1'b1, 5, "stall5");

    // Reset during SHIFT.
    @(negedge clk);
    in_data = 8'hF0; in_amt = 4'd6; in_arith = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("midrst busy before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst busy", busy, 0);
    chk("midrst in_ready", in_ready, 1);
    chk("midrst out_data", out_data, 0);
    chk("midrst sticky", out_sticky, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h6C, 4'd6, 1'b0, 8'h01, 1'b1, 0, "after_rst");

    for (int i = 0; i < 20; i++) begin
      rd  = 8'($urandom);
      ra  = 4'($urandom);
      rar = 1'($urandom);
      model(rd, ra, rar, r, s);
      run_op(rd, ra, rar, r, s, int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
